// File: rtl/pkt_defs.sv
// Shared encodings for the packet capture controller: FSM state codes and
// the default sync header bytes.
package pkt_defs;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_S1      = 3'd1;
  localparam logic [2:0] ST_S2      = 3'd2;
  localparam logic [2:0] ST_LEN     = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;
  localparam logic [7:0] SYNC2_DEFAULT = 8'hF0;

endpackage

// File: rtl/pkt_buf.sv
// Payload storage: register array with a synchronous write port and an
// asynchronous read port. Contents are data only and are never reset.
module pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_capture_ctrl.sv
// Byte-stream packet capture: hunts a 3-byte sync header, reads a length byte,
// buffers the payload and drains it over a valid/ready handshake.
module packet_capture_ctrl
  import pkt_defs::*;
#(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       sync0,
  input  logic [7:0]       sync1,
  input  logic [7:0]       sync2,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [2:0]       state
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       wr_ptr_q, wr_ptr_d;
  logic [7:0]       rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             wr_en;
  logic [7:0]       buf_rdata;
  logic [7:0]       last_idx;
  logic             hunting;

  assign last_idx = len_q - 8'd1;
  assign hunting  = (state_q == ST_S1) || (state_q == ST_S2) ||
                    (state_q == ST_LEN) || (state_q == ST_PAYLOAD);

  pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pkt_d    = pkt_q;
    err_d    = err_q;
    drop_d   = drop_q;
    tmo_d    = '0;
    wr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && enable && (in_data == sync0)) state_d = ST_S1;
      end
      ST_S1: begin
        if (in_valid) begin
          if (in_data == sync1)      state_d = ST_S2;
          else if (in_data == sync0) state_d = ST_S1;
          else                       state_d = ST_IDLE;
        end
      end
      ST_S2: begin
        if (in_valid) begin
          if (in_data == sync2)      state_d = ST_LEN;
          else if (in_data == sync0) state_d = ST_S1;
          else                       state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (in_valid) begin
          if ((in_data != 8'd0) && (in_data <= 8'(MAX_LEN))) begin
            len_d    = in_data;
            wr_ptr_d = 8'd0;
            state_d  = ST_PAYLOAD;
          end else begin
            err_d   = sat_inc(err_q);
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == last_idx) begin
            rd_ptr_d = 8'd0;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (in_valid) drop_d = sat_inc(drop_q);
        if (out_valid_q && out_ready) begin
          if (rd_ptr_q == last_idx) begin
            pkt_d   = sat_inc(pkt_q);
            state_d = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle-cycle watchdog; an accepted byte leaves tmo_d at its cleared default.
    if (hunting && !in_valid) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        err_d   = sat_inc(err_q);
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Output register stage; the final payload byte is forwarded straight from
  // in_data because it lands in the array on the same edge.
  always_comb begin
    out_valid_d = (state_d == ST_DRAIN);
    out_data_d  = 8'h00;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) out_data_d = in_data;
      else                                                   out_data_d = buf_rdata;
      out_last_d = (rd_ptr_d == (len_d - 8'd1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      tmo_q       <= '0;
      pkt_q       <= '0;
      err_q       <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      pkt_q       <= pkt_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign state      = state_q;
  assign pkt_count  = pkt_q;
  assign err_count  = err_q;
  assign drop_count = drop_q;

endmodule
